// File: rtl/norz_mem_responder.sv
// norz_mem_responder
// Memory-side target for the NORZ CPU memory-access cycle. Decodes the
// address against a 2^AW-byte window at BASE, stretches the cycle with WAIT
// for WAIT_STATES cycles, then either drives read data or commits one write
// into the internal byte array. Offsets below ROM_TOP are write-protected.
//
// Ports:
//   CLK       in   system clock, rising edge
//   notRESET  in   asynchronous active-low reset
//   Ad        in   16-bit CPU address
//   Dt_in     in   8-bit write data
//   MREQ      in   memory request (active high)
//   RD / WR   in   read / write strobes (active high)
//   Dt_out    out  registered read data
//   Dt_oe     out  drive enable for Dt_out
//   WAIT      out  cycle-stretch request
//   Bus_err   out  one-cycle pulse on RD & WR collision
//   Busy      out  high whenever the block is not idle
module norz_mem_responder #(
    parameter int          AW          = 12,
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int          WAIT_STATES = 1,
    parameter int          ROM_TOP     = 0
) (
    input  logic          CLK,
    input  logic          notRESET,
    input  logic [15:0]   Ad,
    input  logic [7:0]    Dt_in,
    input  logic          MREQ,
    input  logic          RD,
    input  logic          WR,
    output logic [7:0]    Dt_out,
    output logic          Dt_oe,
    output logic          WAIT,
    output logic          Bus_err,
    output logic          Busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RD   = 3'd1,
        DRIVE_RD  = 3'd2,
        WAIT_WR   = 3'd3,
        COMMIT_WR = 3'd4,
        HOLD      = 3'd5
    } state_t;

    // Counter load value: WAIT stays high for WAIT_STATES cycles, so the
    // counter starts one below and the exit happens on the cycle it reads 0.
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam bit          NO_WAIT = (WAIT_STATES == 0);
    localparam logic [16:0] ROM_LIM = 17'(ROM_TOP);

    state_t          state_r, state_nxt_s;
    logic [3:0]      cnt_r, cnt_nxt_s;
    logic [AW-1:0]   addr_r, addr_nxt_s;
    logic [7:0]      wdata_r, wdata_nxt_s;
    logic            wait_nxt_s, oe_nxt_s, err_nxt_s;
    logic            load_dout_s, mem_we_s, sel_s, rom_hit_s;
    logic [AW-1:0]   rd_addr_s;
    logic [7:0]      mem_r [2**AW];

    assign sel_s     = MREQ && (Ad[15:AW] == BASE[15:AW]);
    assign rom_hit_s = ({{(17-AW){1'b0}}, addr_r} < ROM_LIM);
    // With zero wait states the array is read straight from the bus address
    // on the request edge, before addr_r holds it.
    assign rd_addr_s = (state_r == IDLE) ? Ad[AW-1:0] : addr_r;

    // Next-state, latch and registered-output decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        wait_nxt_s  = 1'b0;
        oe_nxt_s    = 1'b0;
        err_nxt_s   = 1'b0;
        load_dout_s = 1'b0;
        mem_we_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (sel_s && RD && WR) begin
                    err_nxt_s   = 1'b1;
                    state_nxt_s = HOLD;
                end else if (sel_s && RD) begin
                    addr_nxt_s = Ad[AW-1:0];
                    cnt_nxt_s  = WS_LOAD;
                    if (NO_WAIT) begin
                        state_nxt_s = DRIVE_RD;
                        load_dout_s = 1'b1;
                        oe_nxt_s    = 1'b1;
                    end else begin
                        state_nxt_s = WAIT_RD;
                        wait_nxt_s  = 1'b1;
                    end
                end else if (sel_s && WR) begin
                    addr_nxt_s  = Ad[AW-1:0];
                    wdata_nxt_s = Dt_in;
                    cnt_nxt_s   = WS_LOAD;
                    if (NO_WAIT) begin
                        state_nxt_s = COMMIT_WR;
                    end else begin
                        state_nxt_s = WAIT_WR;
                        wait_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_RD: begin
                if (!MREQ) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_nxt_s = DRIVE_RD;
                    load_dout_s = 1'b1;
                    oe_nxt_s    = 1'b1;
                end else begin
                    cnt_nxt_s  = cnt_r - 4'd1;
                    wait_nxt_s = 1'b1;
                end
            end
            DRIVE_RD: begin
                if (MREQ && RD) begin
                    oe_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_WR: begin
                if (!MREQ) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_nxt_s = COMMIT_WR;
                end else begin
                    cnt_nxt_s  = cnt_r - 4'd1;
                    wait_nxt_s = 1'b1;
                end
            end
            COMMIT_WR: begin
                // Protected offsets drop the write silently.
                mem_we_s    = !rom_hit_s;
                state_nxt_s = HOLD;
            end
            HOLD: begin
                if (!MREQ) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, access latches and registered outputs.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            wdata_r <= 8'h00;
            Dt_out  <= 8'h00;
            Dt_oe   <= 1'b0;
            WAIT    <= 1'b0;
            Bus_err <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            addr_r  <= addr_nxt_s;
            wdata_r <= wdata_nxt_s;
            Dt_oe   <= oe_nxt_s;
            WAIT    <= wait_nxt_s;
            Bus_err <= err_nxt_s;
            Busy    <= (state_nxt_s != IDLE);
            if (load_dout_s) begin
                Dt_out <= mem_r[rd_addr_s];
            end
        end
    end

    // Backing byte array; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_norz_mem_responder.sv
// Self-checking bench for norz_mem_responder. Three instances cover the
// parameter corners: u0 (1 wait state, BASE 0), u1 (0 wait states, BASE 0),
// u2 (15 wait states, BASE 8000, ROM_TOP 0100). A byte-array model with
// learned initial contents predicts every readback.
module tb_norz_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ad_a   [3];
    logic [7:0]  din_a  [3];
    logic        mreq_a [3];
    logic        rd_a   [3];
    logic        wr_a   [3];
    wire  [7:0]  dout_w [3];
    wire         oe_w   [3];
    wire         wait_w [3];
    wire         err_w  [3];
    wire         busy_w [3];

    int          ws_p   [3] = '{1, 0, 15};
    logic [15:0] base_p [3] = '{16'h0000, 16'h0000, 16'h8000};
    int          rom_p  [3] = '{0, 0, 16'h0100};

    logic [7:0]  mdl [3][4096];
    bit          kn  [3][4096];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    norz_mem_responder #(.AW(12), .BASE(16'h0000), .WAIT_STATES(1), .ROM_TOP(0)) u0 (
        .CLK(clk), .notRESET(rst_n), .Ad(ad_a[0]), .Dt_in(din_a[0]), .MREQ(mreq_a[0]),
        .RD(rd_a[0]), .WR(wr_a[0]), .Dt_out(dout_w[0]), .Dt_oe(oe_w[0]), .WAIT(wait_w[0]),
        .Bus_err(err_w[0]), .Busy(busy_w[0]));
    norz_mem_responder #(.AW(12), .BASE(16'h0000), .WAIT_STATES(0), .ROM_TOP(0)) u1 (
        .CLK(clk), .notRESET(rst_n), .Ad(ad_a[1]), .Dt_in(din_a[1]), .MREQ(mreq_a[1]),
        .RD(rd_a[1]), .WR(wr_a[1]), .Dt_out(dout_w[1]), .Dt_oe(oe_w[1]), .WAIT(wait_w[1]),
        .Bus_err(err_w[1]), .Busy(busy_w[1]));
    norz_mem_responder #(.AW(12), .BASE(16'h8000), .WAIT_STATES(15), .ROM_TOP(16'h0100)) u2 (
        .CLK(clk), .notRESET(rst_n), .Ad(ad_a[2]), .Dt_in(din_a[2]), .MREQ(mreq_a[2]),
        .RD(rd_a[2]), .WR(wr_a[2]), .Dt_out(dout_w[2]), .Dt_oe(oe_w[2]), .WAIT(wait_w[2]),
        .Bus_err(err_w[2]), .Busy(busy_w[2]));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input int k, input logic [15:0] a);
        return a[15:12] == base_p[k][15:12];
    endfunction

    task automatic idle_bus(input int k);
        mreq_a[k] = 1'b0; rd_a[k] = 1'b0; wr_a[k] = 1'b0;
    endtask

    // Access to an address outside the window: nothing may respond.
    task automatic unsel(input int k, input logic [15:0] a, input bit wr, input logic [7:0] d);
        ad_a[k] = a; din_a[k] = d; mreq_a[k] = 1'b1; rd_a[k] = !wr; wr_a[k] = wr;
        @(negedge clk);
        chk("unsel_wait", 16'(wait_w[k]), 16'd0);
        chk("unsel_oe",   16'(oe_w[k]),   16'd0);
        chk("unsel_busy", 16'(busy_w[k]), 16'd0);
        idle_bus(k);
        @(negedge clk);
    endtask

    task automatic do_write(input int k, input logic [15:0] a, input logic [7:0] d);
        logic [11:0] off = a[11:0];
        ad_a[k] = a; din_a[k] = d; mreq_a[k] = 1'b1; wr_a[k] = 1'b1; rd_a[k] = 1'b0;
        for (int i = 0; i < ws_p[k]; i++) begin
            @(negedge clk);
            chk("wr_wait_hi", 16'(wait_w[k]), 16'd1);
            chk("wr_busy",    16'(busy_w[k]), 16'd1);
            ad_a[k] = 16'($urandom); din_a[k] = 8'($urandom);
        end
        @(negedge clk);
        chk("wr_wait_lo", 16'(wait_w[k]), 16'd0);
        chk("wr_busy_c",  16'(busy_w[k]), 16'd1);
        @(negedge clk);
        chk("wr_busy_h",  16'(busy_w[k]), 16'd1);
        if (int'(off) >= rom_p[k]) begin
            mdl[k][off] = d; kn[k][off] = 1'b1;
        end
        idle_bus(k);
        @(negedge clk);
        chk("wr_busy_end", 16'(busy_w[k]), 16'd0);
    endtask

    task automatic do_read(input int k, input logic [15:0] a);
        logic [11:0] off = a[11:0];
        ad_a[k] = a; mreq_a[k] = 1'b1; rd_a[k] = 1'b1; wr_a[k] = 1'b0;
        for (int i = 0; i < ws_p[k]; i++) begin
            @(negedge clk);
            chk("rd_wait_hi", 16'(wait_w[k]), 16'd1);
            chk("rd_oe_lo",   16'(oe_w[k]),   16'd0);
            ad_a[k] = 16'($urandom);
        end
        @(negedge clk);
        chk("rd_wait_lo", 16'(wait_w[k]), 16'd0);
        chk("rd_oe_hi",   16'(oe_w[k]),   16'd1);
        if (kn[k][off]) begin
            chk("rd_data", 16'(dout_w[k]), 16'(mdl[k][off]));
        end else begin
            mdl[k][off] = dout_w[k]; kn[k][off] = 1'b1;
        end
        @(negedge clk);
        chk("rd_hold_oe",   16'(oe_w[k]),   16'd1);
        chk("rd_hold_data", 16'(dout_w[k]), 16'(mdl[k][off]));
        idle_bus(k);
        @(negedge clk);
        chk("rd_end_oe",   16'(oe_w[k]),   16'd0);
        chk("rd_end_busy", 16'(busy_w[k]), 16'd0);
        chk("rd_end_keep", 16'(dout_w[k]), 16'(mdl[k][off]));
    endtask

    task automatic access(input int k, input logic [15:0] a, input bit wr, input logic [7:0] d);
        if (in_win(k, a)) begin
            if (wr) do_write(k, a, d);
            else    do_read(k, a);
        end else begin
            unsel(k, a, wr, d);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            ad_a[k] = 16'h0000; din_a[k] = 8'h00; idle_bus(k);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_dout", 16'(dout_w[k]), 16'h0000);
            chk("rst_oe",   16'(oe_w[k]),   16'd0);
            chk("rst_wait", 16'(wait_w[k]), 16'd0);
            chk("rst_err",  16'(err_w[k]),  16'd0);
            chk("rst_busy", 16'(busy_w[k]), 16'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Write/readback, then zero-wait instance.
        do_write(0, 16'h0123, 8'hA5);
        do_read(0, 16'h0123);
        do_write(1, 16'h0456, 8'h5A);
        do_read(1, 16'h0456);

        // Window decode and 15 wait states on u2.
        do_read(2, 16'h8000);
        unsel(2, 16'h1000, 1'b1, 8'h77);
        do_read(2, 16'h8000);
        do_write(2, 16'h8010, 8'hC3);
        do_read(2, 16'h8010);

        // ROM protection on u2.
        do_read(2, 16'h8080);
        do_write(2, 16'h8080, 8'h3C);
        do_read(2, 16'h8080);
        do_write(2, 16'h8200, 8'h3C);
        do_read(2, 16'h8200);

        // Abort during WAIT_WR.
        ad_a[0] = 16'h0123; din_a[0] = 8'h11; mreq_a[0] = 1'b1; wr_a[0] = 1'b1;
        @(negedge clk);
        chk("abort_wait_hi", 16'(wait_w[0]), 16'd1);
        idle_bus(0);
        @(negedge clk);
        chk("abort_wait_lo", 16'(wait_w[0]), 16'd0);
        chk("abort_busy",    16'(busy_w[0]), 16'd0);
        do_read(0, 16'h0123);

        // Collision: RD and WR together.
        ad_a[0] = 16'h0123; din_a[0] = 8'h22; mreq_a[0] = 1'b1; rd_a[0] = 1'b1; wr_a[0] = 1'b1;
        @(negedge clk);
        chk("coll_err",  16'(err_w[0]),  16'd1);
        chk("coll_busy", 16'(busy_w[0]), 16'd1);
        chk("coll_oe",   16'(oe_w[0]),   16'd0);
        @(negedge clk);
        chk("coll_err_pulse", 16'(err_w[0]),  16'd0);
        chk("coll_hold",      16'(busy_w[0]), 16'd1);
        idle_bus(0);
        @(negedge clk);
        chk("coll_release", 16'(busy_w[0]), 16'd0);
        do_read(0, 16'h0123);

        // Randomized traffic on u0 and u1.
        for (int n = 0; n < 60; n++) begin
            int k = n % 2;
            logic [15:0] a = 16'h0100 + 16'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) a = a | 16'h5000;
            access(k, a, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Asynchronous reset in the middle of DRIVE_RD.
        ad_a[0] = 16'h0123; mreq_a[0] = 1'b1; rd_a[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("arst_pre_oe", 16'(oe_w[0]), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe",   16'(oe_w[0]),   16'd0);
        chk("arst_wait", 16'(wait_w[0]), 16'd0);
        chk("arst_busy", 16'(busy_w[0]), 16'd0);
        idle_bus(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(0, 16'h0123);
        do_read(1, 16'h0456);
        do_read(2, 16'h8200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/norz_mem_responder.md
Name: norz_mem_responder

Overview:
- Memory-side bus target for the NORZ CPU memory-access cycle.
- The CPU raises MREQ with RD or WR and a 16-bit address. This block decodes the address against its window, stretches the cycle with WAIT, and then either returns read data on the data bus or commits write data into its internal byte array.
- It is the responder end of the cycle that the CPU's MA/M1 decoders initiate. It sits between the CPU pins and the backing store.

Parameters:
- AW, 12, array address bits; array depth is 2^AW bytes, indexed by Ad[AW-1:0].
- BASE, 16'h0000, window base; the block is selected when Ad[15:AW] == BASE[15:AW].
- WAIT_STATES, 1, number of cycles WAIT is held high per access; legal range 0..15.
- ROM_TOP, 0, window offsets below ROM_TOP are write-protected; 0 means the whole window is writable.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- notRESET  in  1  asynchronous, active-low reset.
- Ad  in  16  address bus from the CPU.
- Dt_in  in  8  write data from the CPU.
- MREQ  in  1  memory request, active high.
- RD  in  1  read strobe, active high.
- WR  in  1  write strobe, active high.
- Dt_out  out  8  read data.
- Dt_oe  out  1  drive enable for Dt_out.
- WAIT  out  1  cycle-stretch request to the CPU, active high.
- Bus_err  out  1  one-cycle pulse when RD and WR are both high with MREQ while selected.
- Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (notRESET=0, asynchronous):
  - state=IDLE; Dt_out=8'h00; Dt_oe=0; WAIT=0; Bus_err=0; Busy=0; wait counter=0.
  - Array contents are not cleared.
- States: IDLE, WAIT_RD, DRIVE_RD, WAIT_WR, COMMIT_WR, HOLD.
- sel = MREQ & (Ad[15:AW]==BASE[15:AW]).
- IDLE:
  - sel & RD & ~WR: latch address; go to WAIT_RD with counter=WAIT_STATES-1 and WAIT=1. If WAIT_STATES=0, go directly to DRIVE_RD.
  - sel & WR & ~RD: latch address and Dt_in; go to WAIT_WR in the same way, or to COMMIT_WR if WAIT_STATES=0.
  - sel & RD & WR: Bus_err=1 for one cycle; go to HOLD; no array access.
  - No select: remain in IDLE; all outputs stay low.
- WAIT_RD / WAIT_WR:
  - WAIT=1; the counter decrements each cycle.
  - When the counter is 0, advance to DRIVE_RD or COMMIT_WR on the next edge; WAIT=0 from that edge.
  - WAIT is registered and high for exactly WAIT_STATES cycles.
- DRIVE_RD:
  - Dt_out is registered from array[latched addr] on the edge that enters this state; Dt_oe=1.
  - Data holds stable while MREQ & RD stay high.
  - On ~MREQ | ~RD: Dt_oe=0 on the next edge; go to IDLE. Dt_out retains its last value.
- COMMIT_WR:
  - Array write occurs on the edge leaving COMMIT_WR (exactly one write), unless offset < ROM_TOP, in which case the write is silently dropped.
  - Then go to HOLD.
- HOLD: wait for MREQ=0, then go to IDLE. This prevents a second access within one CPU cycle.
- Abort: MREQ falling during WAIT_RD/WAIT_WR returns the block to IDLE on the next edge, with WAIT=0, no write and no drive.
- Address, Dt_in, RD and WR changes after the latch are ignored for the current access.
- Read-after-write to the same address in back-to-back cycles returns the new data.
- Reset mid-access: immediate IDLE; a write not yet committed is lost; the array is otherwise unchanged.
- Counter width is 4 bits; WAIT_STATES>15 is illegal and is not checked in RTL.

Test Plan:
- Write/readback: WAIT_STATES=1, BASE=0. Write 8'hA5 to 16'h0123, then read 16'h0123. WAIT is high 1 cycle for each access; Dt_out=8'hA5 with Dt_oe=1 in DRIVE_RD.
- Zero-wait and max-wait:
  - WAIT_STATES=0: a read never raises WAIT, and Dt_oe rises on the edge after the request.
  - WAIT_STATES=15: WAIT is high for exactly 15 cycles.
- Window decode: BASE=16'h8000, AW=12. An access to 16'h1000 gives WAIT=0, Dt_oe=0, Busy=0, and the array is unchanged. An access to 16'h8010 responds normally.
- ROM protect: ROM_TOP=16'h0100. Write 8'h3C to offset 16'h0080 and then read it: the prior value is returned. Write to offset 16'h0200 and read it: 8'h3C is returned.
- Abort and collision:
  - Drop MREQ during WAIT_WR: WAIT falls next edge, and a later read shows the old data.
  - MREQ=RD=WR=1: Bus_err pulses for one cycle, the block sits in HOLD until MREQ=0, and there is no array write.
- Async reset: assert notRESET=0 mid-DRIVE_RD between edges. Dt_oe, WAIT and Busy drop immediately; previously written data survives a later readback.
